// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, releases the clock with a start bit,
// then shifts a command byte out on device-generated clock edges and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       CLK_25MHZ,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       PS2_CLK_LOW,
    output logic       PS2_DATA_LOW,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TX_DONE,
    output logic       TX_ERROR
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, RECOVER} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic             data_low_q, data_low_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic             clk_s1_q, clk_s2_q, clk_s3_q;
    logic             dat_s1_q, dat_s2_q;
    logic             clk_fall;

    // Synchronizers idle high so reset never fakes a falling edge.
    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_s3_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= PS2_CLK;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            dat_s1_q <= PS2_DATA;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign clk_fall = clk_s3_q & ~clk_s2_q;

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            data_low_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            data_low_q <= data_low_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge CLK_25MHZ) begin
        byte_q <= byte_d;
        par_q  <= par_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        data_low_d = data_low_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        byte_d     = byte_q;
        par_d      = par_q;
        case (state_q)
            IDLE: begin
                data_low_d = 1'b0;
                if (TX_VALID) begin
                    byte_d  = TX_DATA;
                    par_d   = ~^TX_DATA;
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d      = '0;
                    data_low_d = 1'b1;
                    state_d    = START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            START: begin
                // The START cycle is the first counted timeout cycle.
                bit_d   = '0;
                cnt_d   = CNT_W'(1);
                state_d = SEND;
            end
            SEND, ACK, RECOVER: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == TMO_LAST) begin
                    err_d      = 1'b1;
                    data_low_d = 1'b0;
                    state_d    = IDLE;
                end else if (state_q == SEND) begin
                    if (clk_fall) begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q < 4'd8) begin
                            data_low_d = ~byte_q[bit_q[2:0]];
                        end else if (bit_q == 4'd8) begin
                            data_low_d = ~par_q;
                        end else begin
                            data_low_d = 1'b0;
                            state_d    = ACK;
                        end
                    end
                end else if (state_q == ACK) begin
                    if (clk_fall) begin
                        if (!dat_s2_q) begin
                            state_d = RECOVER;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else if (clk_s2_q && dat_s2_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drive outputs decode the registered state so reset releases the bus immediately.
    assign PS2_CLK_LOW  = (state_q == INHIBIT);
    assign PS2_DATA_LOW = ((state_q == INHIBIT) && (cnt_q == INH_LAST)) ||
                          (((state_q == START) || (state_q == SEND)) && data_low_q);
    assign TX_READY     = (state_q == IDLE);
    assign TX_DONE      = done_q;
    assign TX_ERROR     = err_q;

endmodule
